datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SelectIns  in  1  instruction-memory bank select: 0 = bank 0, 1 = bank 1.
REQ-004 RegWrite  in  1  register-file write enable.
REQ-005 RegDst  in  1  write-register select: 0 = instr[20:16] (rt), 1 = instr[15:11] (rd).
REQ-006 ALUSrcA  in  1  ALU A select: 0 = PC, 1 = register rs.
REQ-007 ALUSrcB  in  2  ALU B select: 00 = register rt, 01 = constant 1, 10 = sign-extended instr[15:0], 11 = zero-extended instr[15:0].
REQ-008 MemWrite  in  1  data-memory write enable.
REQ-009 MemtoReg  in  1  write-back select: 0 = ALU result, 1 = data-memory read data.
REQ-010 BEQ  in  1  branch qualifier: branch taken only when BEQ=1 and ALU zero=1.
REQ-011 PCSrc  in  2  next-PC select: 00 = PC+1, 01 = branch, 10 = jump, 11 = register rs.
REQ-012 pc_out  out  32  current PC (word address).
REQ-013 instr_out  out  32  current instruction.
REQ-014 alu_out  out  32  current ALU result.

Function
REQ-015 Datapath SHALL be 32-bit, word-addressed; one instruction completes per clk cycle under the applied controls.
REQ-016 Instruction SHALL be read combinationally from bank[SelectIns] at address PC[4:0]; each bank SHALL be 32 x 32-bit ROM, contents from init-file parameters.
REQ-017 Register file SHALL be 32 x 32-bit, two async read ports (rs = instr[25:21], rt = instr[20:16]), one sync write port; register 0 SHALL read 0 and ignore writes.
REQ-018 ALU operation SHALL be decoded internally from instr: opcode 0 uses funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt signed); opcode 0x08 addi, 0x23 lw, 0x2B sw -> add; 0x0C andi -> and; 0x0D ori -> or; 0x04 beq -> sub; any other -> add.
REQ-019 ALU arithmetic SHALL wrap modulo 2^32; no overflow flag; zero = (result == 0).
REQ-020 Data memory SHALL be 32 x 32-bit, address alu_out[4:0], async read, write of rt data on clk edge when MemWrite=1.
REQ-021 Write-back data SHALL be MemtoReg mux output, written to RegDst-selected register on clk edge when RegWrite=1.
REQ-022 Next PC: 00 -> PC+1; 01 -> (BEQ & zero) ? PC+1+signext(imm) : PC+1; 10 -> {PC[31:26], instr[25:0]}; 11 -> rs value; PC SHALL update every clk edge.
REQ-023 PC+1 and branch target SHALL use dedicated adders, independent of the main ALU.
REQ-024 Simultaneous RegWrite and MemWrite SHALL both take effect in the same edge; a read of a register written this edge SHALL return the old value.
REQ-025 PC wrap: PC+1 from 0xFFFFFFFF SHALL yield 0; instruction fetch uses PC[4:0] only (aliasing).

Reset
REQ-026 reset=1 SHALL set PC=0, all registers=0, all data-memory words=0 at the next rising edge, overriding RegWrite/MemWrite.
REQ-027 Outputs after reset: pc_out=0, instr_out=bank[SelectIns][0], alu_out per combinational path.
REQ-028 Reset asserted mid-program SHALL discard that cycle's writes; execution restarts at PC=0 on the first edge with reset=0.

Structure
REQ-029 Shared package SHALL hold opcode/funct constants, ALU-operation enum, and ALUSrcB/PCSrc encodings.
REQ-030 ALU SHALL be one sub-module named alu (inputs a, b, op; outputs result, zero); register file, memories, muxes inline.

Verification
REQ-031 Reset, then hold reset=0, PCSrc=00 -> pc_out 0,1,2,3 on successive edges.
REQ-032 instr addi r1,r0,5 with RegWrite=1, ALUSrcA=1, ALUSrcB=10 -> r1=5; then add r3,r1,r1 with RegDst=1, ALUSrcB=00 -> r3=10, alu_out=10.
REQ-033 r1=r2=5, beq r1,r2,+3 at PC=4, BEQ=1, PCSrc=01 -> pc_out=8; with r2=6 -> pc_out=5.
REQ-034 sw r1,7(r0) with MemWrite=1, ALUSrcB=10 (r1=5); then lw r4,7(r0) with MemtoReg=1, RegWrite=1 -> r4=5.
REQ-035 jump instr target field 0x10, PCSrc=10 -> pc_out=16; write to r0 -> r0 still reads 0.
REQ-036 reset asserted mid-program with RegWrite=1 -> no register written, pc_out=0 next cycle.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants, encodings and the ALU operation decode for the datapath.
package datapath_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned NREGS      = 32;
   localparam int unsigned DMEM_WORDS = 32;
   localparam int unsigned ROM_WORDS  = 32;
   localparam int unsigned ADDR_W     = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT
   } alu_op_e;

   typedef enum logic [1:0] {
      SRCB_RT   = 2'b00,
      SRCB_ONE  = 2'b01,
      SRCB_SEXT = 2'b10,
      SRCB_ZEXT = 2'b11
   } srcb_e;

   typedef enum logic [1:0] {
      PCSRC_INC    = 2'b00,
      PCSRC_BRANCH = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_REG    = 2'b11
   } pcsrc_e;

   typedef struct packed {
      logic [5:0] opcode;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic [4:0] shamt;
      logic [5:0] funct;
   } instr_t;

   // Map opcode/funct to an ALU operation; anything unrecognised adds.
   function automatic alu_op_e alu_decode(input instr_t ins);
      alu_op_e op;
      op = ALU_ADD;
      if (ins.opcode == OP_RTYPE) begin
         case (ins.funct)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_XOR:  op = ALU_XOR;
            FN_NOR:  op = ALU_NOR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
         endcase
      end else begin
         case (ins.opcode)
            OP_ADDI, OP_LW, OP_SW: op = ALU_ADD;
            OP_ANDI:               op = ALU_AND;
            OP_ORI:                op = ALU_OR;
            OP_BEQ:                op = ALU_SUB;
            default:               op = ALU_ADD;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/datapath_alu.sv
// Main ALU: wrapping arithmetic, bitwise ops and signed set-less-than.
module alu
   import datapath_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_op_e         op,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   // Operation select and zero detect
   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_NOR: result = ~(a | b);
         ALU_SLT: result = XLEN'($signed(a) < $signed(b));
         default: result = a + b;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/datapath.sv
// Single-cycle 32-bit word-addressed datapath driven by external control lines.
module datapath
   import datapath_pkg::*;
#(
   parameter logic [ROM_WORDS*XLEN-1:0] BANK0_INIT = '0,
   parameter logic [ROM_WORDS*XLEN-1:0] BANK1_INIT = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            SelectIns,
   input  logic            RegWrite,
   input  logic            RegDst,
   input  logic            ALUSrcA,
   input  logic [1:0]      ALUSrcB,
   input  logic            MemWrite,
   input  logic            MemtoReg,
   input  logic            BEQ,
   input  logic [1:0]      PCSrc,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] instr_out,
   output logic [XLEN-1:0] alu_out
);

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   regs_q [NREGS];
   logic [XLEN-1:0]   regs_d [NREGS];
   logic [XLEN-1:0]   dmem_q [DMEM_WORDS];
   logic [XLEN-1:0]   dmem_d [DMEM_WORDS];

   logic [ADDR_W-1:0] rom_addr;
   instr_t            ins;
   logic [XLEN-1:0]   rs_val, rt_val, imm_sext, imm_zext;
   logic [XLEN-1:0]   alu_a, alu_b, alu_res;
   logic              alu_zero;
   alu_op_e           alu_op;
   logic [XLEN-1:0]   pc_plus1, branch_tgt, dmem_rdata, wb_data;
   logic [4:0]        wr_addr;

   // Fetch, register read and ALU operand selection
   always_comb begin
      rom_addr = pc_q[ADDR_W-1:0];
      ins      = SelectIns ? instr_t'(BANK1_INIT[rom_addr*XLEN +: XLEN])
                           : instr_t'(BANK0_INIT[rom_addr*XLEN +: XLEN]);
      rs_val   = (ins.rs == '0) ? '0 : regs_q[ins.rs];
      rt_val   = (ins.rt == '0) ? '0 : regs_q[ins.rt];
      imm_sext = {{16{ins.rd[4]}}, ins.rd, ins.shamt, ins.funct};
      imm_zext = {16'h0000, ins.rd, ins.shamt, ins.funct};
      alu_a    = ALUSrcA ? rs_val : pc_q;
      case (srcb_e'(ALUSrcB))
         SRCB_RT:   alu_b = rt_val;
         SRCB_ONE:  alu_b = XLEN'(1);
         SRCB_SEXT: alu_b = imm_sext;
         default:   alu_b = imm_zext;
      endcase
      alu_op   = alu_decode(ins);
   end

   alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .op     (alu_op),
      .result (alu_res),
      .zero   (alu_zero)
   );

   // Next PC, write-back and memory write; reads see pre-edge contents
   always_comb begin
      pc_plus1   = pc_q + XLEN'(1);
      branch_tgt = pc_plus1 + imm_sext;
      dmem_rdata = dmem_q[alu_res[ADDR_W-1:0]];
      wb_data    = MemtoReg ? dmem_rdata : alu_res;
      wr_addr    = RegDst ? ins.rd : ins.rt;
      regs_d     = regs_q;
      dmem_d     = dmem_q;
      case (pcsrc_e'(PCSrc))
         PCSRC_INC:    pc_d = pc_plus1;
         PCSRC_BRANCH: pc_d = (BEQ && alu_zero) ? branch_tgt : pc_plus1;
         PCSRC_JUMP:   pc_d = {pc_q[31:26], ins.rs, ins.rt, ins.rd, ins.shamt, ins.funct};
         default:      pc_d = rs_val;
      endcase
      if (RegWrite && (wr_addr != '0)) begin
         regs_d[wr_addr] = wb_data;
      end
      if (MemWrite) begin
         dmem_d[alu_res[ADDR_W-1:0]] = rt_val;
      end
   end

   // State update; synchronous reset clears PC, registers and data memory
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= '0;
         regs_q <= '{default: '0};
         dmem_q <= '{default: '0};
      end else begin
         pc_q   <= pc_d;
         regs_q <= regs_d;
         dmem_q <= dmem_d;
      end
   end

   assign pc_out    = pc_q;
   assign instr_out = ins;
   assign alu_out   = alu_res;

endmodule

// File: tb/tb_datapath.sv
// Directed program plus randomized control sequence checked against an ISA-level model.
module tb_datapath;

   // Program banks: bank 0 holds a directed program at fixed addresses, the rest pseudo-random
   function automatic logic [1023:0] gen_bank(input int unsigned which);
      logic [1023:0] v;
      logic [31:0]   s;
      logic [31:0]   w;
      logic [5:0]    op;
      logic [5:0]    fn;
      v = '0;
      s = 32'h9E37_79B9 ^ (which * 32'h0101_0101);
      for (int i = 0; i < 32; i++) begin
         s = s ^ (s << 13);
         s = s ^ (s >> 17);
         s = s ^ (s << 5);
         case (s[31:29])
            3'd0: op = 6'h00;
            3'd1: op = 6'h08;
            3'd2: op = 6'h0C;
            3'd3: op = 6'h0D;
            3'd4: op = 6'h23;
            3'd5: op = 6'h2B;
            3'd6: op = 6'h04;
            default: op = 6'h3F;
         endcase
         case (s[2:0])
            3'd0: fn = 6'h20;
            3'd1: fn = 6'h22;
            3'd2: fn = 6'h24;
            3'd3: fn = 6'h25;
            3'd4: fn = 6'h26;
            3'd5: fn = 6'h27;
            default: fn = 6'h2A;
         endcase
         w = {op, s[25:0]};
         if (op == 6'h00) w[10:0] = {5'd0, fn};
         if (which == 0) begin
            case (i)
               0:  w = 32'h2001_0005; // addi r1,r0,5
               1:  w = 32'h0021_1820; // add  r3,r1,r1
               2:  w = 32'h2002_0005; // addi r2,r0,5
               3:  w = 32'hAC01_0007; // sw   r1,7(r0)
               4:  w = 32'h1022_0003; // beq  r1,r2,+3
               5:  w = 32'h8C04_0007; // lw   r4,7(r0)
               6:  w = 32'h0800_0010; // j    0x10
               8:  w = 32'h2000_0009; // addi r0,r0,9
               9:  w = 32'h2002_0006; // addi r2,r0,6
               10: w = 32'h0800_0004; // j    4
               11: w = 32'h2005_FFFF; // addi r5,r0,-1
               12: w = 32'h00A0_3020; // add  r6,r5,r0
               16: w = 32'h0800_000B; // j    11
               default: ;
            endcase
         end
         v[i*32 +: 32] = w;
      end
      return v;
   endfunction

   localparam logic [1023:0] B0 = gen_bank(0);
   localparam logic [1023:0] B1 = gen_bank(1);

   logic        clk = 1'b0;
   logic        reset, SelectIns, RegWrite, RegDst, ALUSrcA, MemWrite, MemtoReg, BEQ;
   logic [1:0]  ALUSrcB, PCSrc;
   logic [31:0] pc_out, instr_out, alu_out;

   datapath #(.BANK0_INIT(B0), .BANK1_INIT(B1)) dut (
      .clk(clk), .reset(reset), .SelectIns(SelectIns), .RegWrite(RegWrite),
      .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .BEQ(BEQ), .PCSrc(PCSrc),
      .pc_out(pc_out), .instr_out(instr_out), .alu_out(alu_out)
   );

   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   int unsigned n_fail  = 0;
   bit          check_on = 1'b0;

   // Architectural model state
   logic [31:0] rom0 [32];
   logic [31:0] rom1 [32];
   logic [31:0] m_pc;
   logic [31:0] m_reg [32];
   logic [31:0] m_mem [32];
   logic [31:0] e_ins, e_rsv, e_rtv, e_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_alu(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      logic [5:0] op;
      logic [5:0] fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'h00) begin
         case (fn)
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
         endcase
      end
      case (op)
         6'h0C: return a & b;
         6'h0D: return a | b;
         6'h04: return a - b;
         default: return a + b;
      endcase
   endfunction

   // Drive one cycle's controls and check the combinational view against the model
   task automatic apply(input logic rst, input logic sel, input logic rw, input logic rd,
                        input logic srca, input logic [1:0] srcb, input logic mw,
                        input logic m2r, input logic beq, input logic [1:0] pcs);
      logic [31:0] a, b, imm_s;
      reset = rst; SelectIns = sel; RegWrite = rw; RegDst = rd; ALUSrcA = srca;
      ALUSrcB = srcb; MemWrite = mw; MemtoReg = m2r; BEQ = beq; PCSrc = pcs;
      #1;
      e_ins = sel ? rom1[m_pc[4:0]] : rom0[m_pc[4:0]];
      imm_s = {{16{e_ins[15]}}, e_ins[15:0]};
      e_rsv = m_reg[e_ins[25:21]];
      e_rtv = m_reg[e_ins[20:16]];
      a = srca ? e_rsv : m_pc;
      case (srcb)
         2'd0: b = e_rtv;
         2'd1: b = 32'd1;
         2'd2: b = imm_s;
         default: b = {16'h0000, e_ins[15:0]};
      endcase
      e_res = m_alu(e_ins, a, b);
      if (check_on) begin
         chk("pc", pc_out, m_pc);
         chk("instr", instr_out, e_ins);
         chk("alu", alu_out, e_res);
      end
   endtask

   // Clock edge: advance the model by one instruction, then return to the falling edge
   task automatic tick();
      logic [31:0] wb, nxt;
      logic [4:0]  wa;
      @(posedge clk);
      if (reset) begin
         m_pc = 32'd0;
         for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'd0;
            m_mem[i] = 32'd0;
         end
      end else begin
         wb  = MemtoReg ? m_mem[e_res[4:0]] : e_res;
         wa  = RegDst ? e_ins[15:11] : e_ins[20:16];
         nxt = m_pc + 32'd1;
         case (PCSrc)
            2'd1: if (BEQ && (e_res == 32'd0)) nxt = m_pc + 32'd1 + {{16{e_ins[15]}}, e_ins[15:0]};
            2'd2: nxt = {m_pc[31:26], e_ins[25:0]};
            2'd3: nxt = e_rsv;
            default: ;
         endcase
         if (MemWrite) m_mem[e_res[4:0]] = e_rtv;
         if (RegWrite && (wa != 5'd0)) m_reg[wa] = wb;
         m_pc = nxt;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         rom0[i]  = B0[i*32 +: 32];
         rom1[i]  = B1[i*32 +: 32];
         m_reg[i] = 32'd0;
         m_mem[i] = 32'd0;
      end
      m_pc = 32'd0;
      @(negedge clk);

      // Reset with writes requested; state is unknown until the edge
      apply(1, 0, 1, 0, 1, 2'd2, 1, 0, 0, 2'd0);
      tick();
      check_on = 1'b1;

      apply(0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 2'd0);
      chk("rst_pc", pc_out, 32'd0);
      chk("rst_instr", instr_out, 32'h2001_0005);
      chk("rst_alu", alu_out, 32'd1);
      chk("rst_r1", dut.regs_q[1], 32'd0);
      SelectIns = 1'b1;
      #1;
      chk("rst_instr_bank1", instr_out, rom1[0]);
      SelectIns = 1'b0;
      #1;

      // Sequential PC
      for (int i = 0; i < 4; i++) begin
         if (i > 0) apply(0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 2'd0);
         chk("pc_seq", pc_out, 32'(i));
         if (i < 3) tick();
      end

      // Reset mid-program discards a pending register and memory write
      apply(1, 0, 1, 0, 1, 2'd2, 1, 0, 0, 2'd0);
      tick();
      chk("midrst_pc", pc_out, 32'd0);
      chk("midrst_r1", dut.regs_q[1], 32'd0);

      apply(0, 0, 1, 0, 1, 2'd2, 0, 0, 0, 2'd0);   // addi r1,r0,5
      chk("addi_alu", alu_out, 32'd5);
      tick();
      chk("addi_r1", dut.regs_q[1], 32'd5);
      apply(0, 0, 1, 1, 1, 2'd0, 0, 0, 0, 2'd0);   // add r3,r1,r1
      chk("add_alu", alu_out, 32'd10);
      tick();
      chk("add_r3", dut.regs_q[3], 32'd10);
      apply(0, 0, 1, 0, 1, 2'd2, 0, 0, 0, 2'd0);   // addi r2,r0,5
      tick();
      apply(0, 0, 0, 0, 1, 2'd2, 1, 0, 0, 2'd0);   // sw r1,7(r0)
      chk("sw_alu", alu_out, 32'd7);
      tick();
      chk("sw_mem7", dut.dmem_q[7], 32'd5);
      apply(0, 0, 0, 0, 1, 2'd0, 0, 0, 1, 2'd1);   // beq taken
      chk("beq_eq_alu", alu_out, 32'd0);
      tick();
      chk("beq_taken_pc", pc_out, 32'd8);
      apply(0, 0, 1, 0, 1, 2'd2, 0, 0, 0, 2'd0);   // addi r0,r0,9
      chk("r0w_alu", alu_out, 32'd9);
      tick();
      chk("r0_zero", dut.regs_q[0], 32'd0);
      apply(0, 0, 1, 0, 1, 2'd2, 0, 0, 0, 2'd0);   // addi r2,r0,6
      chk("r0_reads_zero", alu_out, 32'd6);
      tick();
      apply(0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 2'd2);   // j 4
      tick();
      chk("jump4_pc", pc_out, 32'd4);
      apply(0, 0, 0, 0, 1, 2'd0, 0, 0, 1, 2'd1);   // beq not taken
      chk("beq_ne_alu", alu_out, 32'hFFFF_FFFF);
      tick();
      chk("beq_not_taken_pc", pc_out, 32'd5);
      apply(0, 0, 1, 0, 1, 2'd2, 0, 1, 0, 2'd0);   // lw r4,7(r0)
      tick();
      chk("lw_r4", dut.regs_q[4], 32'd5);
      apply(0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 2'd2);   // j 0x10
      tick();
      chk("jump16_pc", pc_out, 32'd16);
      apply(0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 2'd2);   // j 11
      tick();
      chk("jump11_pc", pc_out, 32'd11);
      apply(0, 0, 1, 0, 1, 2'd2, 0, 0, 0, 2'd0);   // addi r5,r0,-1
      chk("addi_neg_alu", alu_out, 32'hFFFF_FFFF);
      tick();
      apply(0, 0, 1, 1, 1, 2'd0, 0, 0, 0, 2'd3);   // jump to rs = r5
      tick();
      chk("jr_pc", pc_out, 32'hFFFF_FFFF);
      apply(0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 2'd0);
      chk("alias_instr", instr_out, rom0[31]);
      tick();
      chk("wrap_pc", pc_out, 32'd0);

      // Randomized controls with occasional reset
      for (int n = 0; n < 600; n++) begin
         r = $urandom;
         apply(r[9:5] == 5'd0, r[0], r[1], r[2], r[3], r[5:4], r[6], r[7], r[8], r[11:10]);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
